// File: rtl/cc_pixel_packer_pkg.sv
`default_nettype none
// =============================================================================
// cc_pixel_packer_pkg : shared state encodings, FIFO entry layout and helpers
// Revision: 1.0
// =============================================================================
package cc_pixel_packer_pkg;

  // One-hot packer states
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_LO    = 4'b0010;
  localparam logic [3:0] ST_HI    = 4'b0100;
  localparam logic [3:0] ST_FLUSH = 4'b1000;

  localparam int unsigned ENTRY_W = 34;

  typedef struct packed {
    logic        eof;
    logic        sof;
    logic [31:0] data;
  } fifo_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_sync_fifo.sv
`default_nettype none
// =============================================================================
// cc_sync_fifo : single-clock first-word-fall-through FIFO with full/empty
// Revision: 1.0
// =============================================================================
module cc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra MSB distinguishes a wrapped (full) pointer pair from an equal (empty) one
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cc_pixel_packer.sv
`default_nettype none
// =============================================================================
// cc_pixel_packer : packs 16-bit pixel pairs into sof/eof-tagged 32-bit words
// Revision: 1.0
// =============================================================================
module cc_pixel_packer
  import cc_pixel_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        cmos_clk_i,
  input  logic        rst,
  input  logic [15:0] cmos_data_i,
  input  logic        cmos_valid_i,
  input  logic        cc_enabled,
  output logic [31:0] m_data_o,
  output logic        m_sof_o,
  output logic        m_eof_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        overflow_o,
  output logic [15:0] drop_count_o,
  output logic [31:0] frame_words_o
);

  logic [3:0]  state_q, state_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_sof_q, pend_sof_d;
  logic        pend_valid_q, pend_valid_d;
  logic        sof_next_q, sof_next_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] frame_words_q, frame_words_d;
  logic        overflow_q, overflow_d;

  logic        accept;
  logic        frame_start;
  logic        form_word;
  logic [31:0] formed;
  logic        push;
  logic        push_ok;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic [1:0]  drop_inc;
  logic [15:0] drop_base;
  logic [31:0] words;
  logic        fifo_full, fifo_empty;

  assign accept = cc_enabled & cmos_valid_i & (state_q != ST_FLUSH);

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    pend_d        = pend_q;
    pend_sof_d    = pend_sof_q;
    pend_valid_d  = pend_valid_q;
    sof_next_d    = sof_next_q;
    overflow_d    = overflow_q;
    frame_words_d = frame_words_q;
    frame_start   = 1'b0;
    form_word     = 1'b0;
    formed        = '0;
    push          = 1'b0;
    push_entry    = '0;
    drop_inc      = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (cc_enabled) begin
          frame_start  = 1'b1;
          pend_valid_d = 1'b0;
          sof_next_d   = 1'b1;
          state_d      = ST_LO;
          if (accept) begin
            lo_d    = cmos_data_i;
            state_d = ST_HI;
          end
        end
      end
      ST_LO: begin
        if (accept) begin
          lo_d    = cmos_data_i;
          state_d = ST_HI;
        end else if (!cc_enabled) begin
          if (pend_valid_q) begin
            push            = 1'b1;
            push_entry.eof  = 1'b1;
            push_entry.sof  = pend_sof_q;
            push_entry.data = pend_q;
          end
          pend_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      ST_HI: begin
        if (accept) begin
          formed    = {cmos_data_i, lo_q};
          form_word = 1'b1;
          state_d   = ST_LO;
        end else if (!cc_enabled) begin
          // Odd pixel count: the lone pixel is padded into the low half
          formed    = {16'h0000, lo_q};
          form_word = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pend_valid_q) begin
          push            = 1'b1;
          push_entry.eof  = 1'b1;
          push_entry.sof  = pend_sof_q;
          push_entry.data = pend_q;
        end
        pend_valid_d = 1'b0;
        state_d      = ST_IDLE;
        if (cc_enabled & cmos_valid_i) begin
          drop_inc = 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A newly formed word displaces the held-back one into the FIFO
    if (form_word) begin
      if (pend_valid_q) begin
        push            = 1'b1;
        push_entry.eof  = 1'b0;
        push_entry.sof  = pend_sof_q;
        push_entry.data = pend_q;
      end
      pend_d       = formed;
      pend_sof_d   = sof_next_q;
      sof_next_d   = 1'b0;
      pend_valid_d = 1'b1;
    end

    push_ok = push & ~fifo_full;
    if (push & fifo_full) begin
      overflow_d = 1'b1;
      drop_inc   = drop_inc + 2'd1;
    end

    drop_base    = frame_start ? 16'h0000 : drop_count_q;
    drop_count_d = sat_add16(drop_base, drop_inc);

    words        = (frame_start ? 32'd0 : word_count_q) + {31'd0, push_ok};
    word_count_d = words;
    if (push & push_entry.eof) begin
      frame_words_d = words;
    end
  end

  always_ff @(posedge cmos_clk_i) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lo_q          <= '0;
      pend_q        <= '0;
      pend_sof_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      sof_next_q    <= 1'b0;
      drop_count_q  <= '0;
      word_count_q  <= '0;
      frame_words_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      pend_q        <= pend_d;
      pend_sof_q    <= pend_sof_d;
      pend_valid_q  <= pend_valid_d;
      sof_next_q    <= sof_next_d;
      drop_count_q  <= drop_count_d;
      word_count_q  <= word_count_d;
      frame_words_q <= frame_words_d;
      overflow_q    <= overflow_d;
    end
  end

  cc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (cmos_clk_i),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (m_ready_i),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields are masked while empty so stale storage never leaks out
  assign m_valid_o     = ~fifo_empty;
  assign m_data_o      = fifo_empty ? 32'd0 : head.data;
  assign m_sof_o       = ~fifo_empty & head.sof;
  assign m_eof_o       = ~fifo_empty & head.eof;
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_count_q;
  assign frame_words_o = frame_words_q;

endmodule
`default_nettype wire
